// File: rtl/line_pkg.sv
// Shared types and constants for the line setup unit.
// Holds the VGA coordinate limits, the raw command record carried through the
// command FIFO, the normalised line record handed to the coordinate
// generator, the setup FSM state type and a range-check helper.
package line_pkg;

  localparam int              COORD_W = 10;
  localparam logic [9:0]      X_MAX   = 10'd639;
  localparam logic [8:0]      Y_MAX   = 9'd479;

  typedef struct packed {
    logic [9:0] x0;
    logic [8:0] y0;
    logic [9:0] x1;
    logic [8:0] y1;
  } line_cmd_t;

  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic               steep;
  } gen_line_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } setup_state_t;

  // True when every endpoint lies on the visible 640x480 raster.
  function automatic logic cmd_in_range(input line_cmd_t c);
    return (c.x0 <= X_MAX) && (c.x1 <= X_MAX) &&
           (c.y0 <= Y_MAX) && (c.y1 <= Y_MAX);
  endfunction

endpackage

// File: rtl/line_cmd_fifo.sv
// Synchronous FIFO of raw line commands.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   i_push, i_data     write request and command (ignored when full)
//   i_pop              read request (ignored when empty)
//   i_flush            empties the FIFO; overrides push and pop on that edge
//   o_data             command at the head (valid when !o_empty)
//   o_full, o_empty    occupancy flags
module line_cmd_fifo
  import line_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      i_push,
  input  line_cmd_t i_data,
  input  logic      i_pop,
  input  logic      i_flush,
  output line_cmd_t o_data,
  output logic      o_full,
  output logic      o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  line_cmd_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign o_data  = r_mem[r_rd];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/line_setup_unit.sv
// Line setup unit: queues raw line commands, normalises each to the
// coordinate generator's contract (x0 <= x1, steep lines pre-swapped) and
// hands them over one at a time with a start/done handshake.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (ready = FIFO not full)
//   cmd_x0/y0/x1/y1               raw endpoints
//   flush                         drop every queued, un-issued command
//   gen_start/gen_done            generator handshake pulses
//   gen_x0/y0/x1/y1, gen_is_steep normalised line, stable while in flight
//   busy                          work in progress or queued
//   cmd_error                     sticky: an out-of-range command was dropped
//   lines_drawn                   saturating count of completed lines
module line_setup_unit
  import line_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [9:0]       cmd_x0,
  input  logic [8:0]       cmd_y0,
  input  logic [9:0]       cmd_x1,
  input  logic [8:0]       cmd_y1,
  input  logic             flush,
  output logic             gen_start,
  input  logic             gen_done,
  output logic [9:0]       gen_x0,
  output logic [9:0]       gen_y0,
  output logic [9:0]       gen_x1,
  output logic [9:0]       gen_y1,
  output logic             gen_is_steep,
  output logic             busy,
  output logic             cmd_error,
  output logic [CNT_W-1:0] lines_drawn
);

  line_cmd_t    w_cmd_in;
  line_cmd_t    w_head;
  logic         w_full;
  logic         w_empty;
  logic         w_pop;
  logic         w_head_ok;
  logic         w_done_inc;
  logic         w_start;
  gen_line_t    w_norm;
  setup_state_t r_state;
  setup_state_t w_state_nxt;
  gen_line_t    r_gen;
  logic         r_err;
  logic [CNT_W-1:0] r_lines;

  // Orient the line so the generator always walks the major axis upwards.
  function automatic gen_line_t normalise(input line_cmd_t c);
    logic [9:0] y0e, y1e, dx, dy, a0, b0, a1, b1;
    logic       steep;
    gen_line_t  r;
    y0e   = {1'b0, c.y0};
    y1e   = {1'b0, c.y1};
    dx    = (c.x1 >= c.x0) ? (c.x1 - c.x0) : (c.x0 - c.x1);
    dy    = (y1e >= y0e) ? (y1e - y0e) : (y0e - y1e);
    steep = (dy > dx);
    if (steep) begin
      a0 = y0e;  b0 = c.x0;  a1 = y1e;  b1 = c.x1;
    end else begin
      a0 = c.x0; b0 = y0e;   a1 = c.x1; b1 = y1e;
    end
    if (a0 > a1) r = '{x0: a1, y0: b1, x1: a0, y1: b0, steep: steep};
    else         r = '{x0: a0, y0: b0, x1: a1, y1: b1, steep: steep};
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_cmd_in = '{x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1};

  line_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (cmd_valid),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .i_flush (flush),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_ok = cmd_in_range(w_head);
  assign w_norm    = normalise(w_head);

  // An invalid head is popped but sends the FSM back to IDLE, so the next
  // entry is considered on the following cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_done_inc  = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && !flush) begin
          w_pop       = 1'b1;
          w_state_nxt = w_head_ok ? ISSUE : IDLE;
        end
      end
      ISSUE: begin
        w_start     = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (gen_done) begin
          w_done_inc = 1'b1;
          if (!w_empty && !flush) begin
            w_pop       = 1'b1;
            w_state_nxt = w_head_ok ? ISSUE : IDLE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_gen   <= '0;
      r_err   <= 1'b0;
      r_lines <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop && w_head_ok)  r_gen   <= w_norm;
      if (w_pop && !w_head_ok) r_err   <= 1'b1;
      if (w_done_inc)          r_lines <= sat_inc(r_lines);
    end
  end

  assign cmd_ready    = !w_full;
  assign gen_start    = w_start;
  assign gen_x0       = r_gen.x0;
  assign gen_y0       = r_gen.y0;
  assign gen_x1       = r_gen.x1;
  assign gen_y1       = r_gen.y1;
  assign gen_is_steep = r_gen.steep;
  assign busy         = (r_state != IDLE) || !w_empty;
  assign cmd_error    = r_err;
  assign lines_drawn  = r_lines;

endmodule

// File: doc/line_setup_unit.md
Name: line_setup_unit

Overview:
- Upstream neighbour of the coordinate generator. Accepts raw line commands (two VGA endpoints), buffers them in a small FIFO, and normalises each one to the generator's contract (x0 <= x1, steep flag, x/y pre-swapped when steep).
- Issues each line with a start pulse and waits for the generator's done pulse before issuing the next.
- Sits between the command source (animation/user logic) and coordinate_generator.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, >= 2)
- CNT_W, 16, width of lines_drawn counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept (= !full)
- cmd_x0  in  10  start x (legal 0..639)
- cmd_y0  in  9  start y (legal 0..479)
- cmd_x1  in  10  end x
- cmd_y1  in  9  end y
- flush  in  1  discard all queued, un-issued commands
- gen_start  out  1  one-cycle start pulse to generator
- gen_done  in  1  one-cycle pulse, generator finished current line
- gen_x0, gen_y0, gen_x1, gen_y1  out  10 each  normalised endpoints
- gen_is_steep  out  1  line is steep; endpoints already x/y-swapped
- busy  out  1  state != IDLE or FIFO non-empty
- cmd_error  out  1  sticky: an out-of-range command was discarded
- lines_drawn  out  CNT_W  completed lines, saturating

Behaviour:
- Reset (reset_n low, async): FIFO empty, state IDLE, gen_start=0, all gen_* coordinates=0, gen_is_steep=0, cmd_error=0, lines_drawn=0, busy=0. cmd_ready=1 once reset releases.
- Push: accepted when cmd_valid && cmd_ready at a rising edge. No bypass when full; space freed by a pop is visible on the next cycle.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if FIFO non-empty, pop the head and load the normalised result into the gen_* registers at that edge. Next state is ISSUE, or IDLE if the command was invalid.
  - ISSUE: gen_start=1 for exactly this cycle. Next state is WAIT.
  - WAIT: gen_start=0. On gen_done, increment lines_drawn (saturate at all-ones). Then, if FIFO non-empty, pop/load and go to ISSUE; otherwise go to IDLE. gen_done in IDLE/ISSUE is ignored.
- Latency: command accepted at end of cycle k into an empty FIFO while IDLE means gen_start is high in cycle k+2.
- Normalisation (combinational on FIFO head, registered on pop):
  - Zero-extend y to 10 bits.
  - dx=|x1-x0|, dy=|y1-y0|.
  - steep = (dy > dx), strict comparison.
  - If steep: a=y, b=x for both endpoints; else a=x, b=y.
  - If a0 > a1, swap endpoints.
  - Outputs: gen_x0=a0, gen_y0=b0, gen_x1=a1, gen_y1=b1, gen_is_steep=steep.
- Validity: a command with any x > 639 or y > 479 is popped but not issued. cmd_error is set (sticky until reset) and the FSM proceeds to the next entry on the following cycle.
- gen_* outputs change only on a valid pop and are held stable through ISSUE and WAIT.
- flush:
  - Empties the FIFO at that edge; it takes priority over a simultaneous push (discarded) and pop (suppressed).
  - Does not affect the in-flight line. In ISSUE the pulse still occurs; in WAIT the FSM still waits for gen_done, then goes to IDLE.
- Degenerate lines: a single point (x0==x1, y0==y1) is issued normally with steep=0.

Decomposition:
- Package line_pkg:
  - X_MAX=639, Y_MAX=479, COORD_W=10
  - typedef struct line_cmd_t {x0,y0,x1,y1}
  - typedef enum setup_state_t {IDLE, ISSUE, WAIT}
- Sub-module line_cmd_fifo: parameterised synchronous FIFO of line_cmd_t with push/pop/flush/full/empty.
- Normalisation stays in line_setup_unit.

Test Plan:
- Shallow line: push (10,20)->(100,25) at cycle k. Required: gen_start in k+2; gen=(10,20)->(100,25); gen_is_steep=0. Then gen_done gives lines_drawn=1 and busy=0.
- Reverse steep: (50,400)->(40,10). Required: gen_x0=10, gen_y0=40, gen_x1=400, gen_y1=50, gen_is_steep=1.
- Diagonal and point: (0,0)->(100,100) gives steep=0 with endpoints unchanged; (5,5)->(5,5) is issued with steep=0.
- Backpressure (DEPTH=4): hold gen_done low and push every cycle. Required: 5 accepted (first popped), then cmd_ready=0. Each gen_done pulse issues the next command in order.
- Invalid command: queue (640,0)->(0,0) then (1,1)->(2,2). Required: no gen_start for the first; cmd_error=1; second issued with gen=(1,1)->(2,2).
- Flush and reset: in WAIT with 3 queued, assert flush, then gen_done. Required: no further gen_start, lines_drawn+1, busy=0. Separately, drop reset_n mid-WAIT: all outputs return to reset values immediately, without waiting for a clock edge.
